// File: rtl/fosfor_present_core.sv
`default_nettype none
// ============================================================================
// Module   : fosfor_present_core
// Brief    : Iterative PRESENT-80/128 block cipher, one round per clock, with a
//            narrow shift-register bus for key/block load and ciphertext read.
//            Option macro FOSFOR_PRESENT_KEY_RETAIN_EN adds a shadow key.
// Revision : 1.0
// ============================================================================
module fosfor_present_core #(
  parameter int KEY_W = 80,
  parameter int BUS_W = 8
) (
  input  logic             Clk_k,
  input  logic             Reset_rn,
  input  logic [BUS_W-1:0] Data_ib,
  input  logic             KeyWr_i,
  input  logic             DataWr_i,
  input  logic             DataRd_i,
  input  logic             Start_i,
  output logic [BUS_W-1:0] Data_ob,
  output logic             Busy_o,
  output logic             Done_o
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_RUN   = 2'd1;
  localparam logic [1:0] c_ST_FINAL = 2'd2;
  localparam logic [4:0] c_RC_LAST  = 5'd31;

  function automatic logic [3:0] f_sbox(input logic [3:0] x);
    case (x)
      4'h0:    f_sbox = 4'hC;
      4'h1:    f_sbox = 4'h5;
      4'h2:    f_sbox = 4'h6;
      4'h3:    f_sbox = 4'hB;
      4'h4:    f_sbox = 4'h9;
      4'h5:    f_sbox = 4'h0;
      4'h6:    f_sbox = 4'hA;
      4'h7:    f_sbox = 4'hD;
      4'h8:    f_sbox = 4'h3;
      4'h9:    f_sbox = 4'hE;
      4'hA:    f_sbox = 4'hF;
      4'hB:    f_sbox = 4'h8;
      4'hC:    f_sbox = 4'h4;
      4'hD:    f_sbox = 4'h7;
      4'hE:    f_sbox = 4'h1;
      default: f_sbox = 4'h2;
    endcase
  endfunction

  logic [1:0]       r_fsm;
  logic [1:0]       w_fsm_nxt;
  logic [4:0]       r_rc;
  logic [63:0]      r_state;
  logic [KEY_W-1:0] r_key;
  logic             r_done;
  logic [63:0]      w_rk;
  logic [63:0]      w_add;
  logic [63:0]      w_sub;
  logic [63:0]      w_perm;
  logic [KEY_W-1:0] w_key_upd;

  assign w_rk  = r_key[KEY_W-1 -: 64];
  assign w_add = r_state ^ w_rk;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      assign w_sub[4*gi +: 4] = f_sbox(w_add[4*gi +: 4]);
    end
    // Bit i moves to i*16 mod 63; bit 63 stays in place.
    for (genvar gb = 0; gb < 64; gb++) begin : g_player
      localparam int c_DST = (gb == 63) ? 63 : ((gb * 16) % 63);
      assign w_perm[c_DST] = w_sub[gb];
    end
  endgenerate

  generate
    if (KEY_W == 128) begin : g_ks128
      logic [127:0] w_rot;
      assign w_rot     = {r_key[66:0], r_key[127:67]};
      assign w_key_upd = {f_sbox(w_rot[127:124]), f_sbox(w_rot[123:120]),
                          w_rot[119:67], w_rot[66:62] ^ r_rc, w_rot[61:0]};
    end else begin : g_ks80
      logic [79:0] w_rot;
      assign w_rot     = {r_key[18:0], r_key[79:19]};
      assign w_key_upd = {f_sbox(w_rot[79:76]), w_rot[75:20],
                          w_rot[19:15] ^ r_rc, w_rot[14:0]};
    end
  endgenerate

`ifdef FOSFOR_PRESENT_KEY_RETAIN_EN
  logic [KEY_W-1:0] r_key_sh;

  always_ff @(posedge Clk_k or negedge Reset_rn) begin
    if (!Reset_rn) begin
      r_key_sh <= '0;
    end else if ((r_fsm == c_ST_IDLE) && !Start_i && KeyWr_i) begin
      r_key_sh <= {r_key_sh[KEY_W-BUS_W-1:0], Data_ib};
    end
  end
`endif

  always_ff @(posedge Clk_k or negedge Reset_rn) begin
    if (!Reset_rn) begin
      r_fsm <= c_ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      c_ST_IDLE:  if (Start_i) w_fsm_nxt = c_ST_RUN;
      c_ST_RUN:   if (r_rc == c_RC_LAST) w_fsm_nxt = c_ST_FINAL;
      c_ST_FINAL: w_fsm_nxt = c_ST_IDLE;
      default:    w_fsm_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_k or negedge Reset_rn) begin
    if (!Reset_rn) begin
      r_state <= '0;
      r_key   <= '0;
      r_rc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_fsm == c_ST_FINAL);
      case (r_fsm)
        c_ST_IDLE: begin
          // Start wins: bus writes and reads in the same cycle are dropped.
          if (Start_i) begin
            r_rc <= 5'd1;
`ifdef FOSFOR_PRESENT_KEY_RETAIN_EN
            r_key <= r_key_sh;
`endif
          end else begin
`ifndef FOSFOR_PRESENT_KEY_RETAIN_EN
            if (KeyWr_i) r_key <= {r_key[KEY_W-BUS_W-1:0], Data_ib};
`endif
            if (DataWr_i) begin
              r_state <= {r_state[63-BUS_W:0], Data_ib};
            end else if (DataRd_i) begin
              r_state <= {r_state[63-BUS_W:0], {BUS_W{1'b0}}};
            end
          end
        end
        c_ST_RUN: begin
          r_state <= w_perm;
          r_key   <= w_key_upd;
          r_rc    <= r_rc + 5'd1;
        end
        c_ST_FINAL: begin
          r_state <= r_state ^ w_rk;
          r_rc    <= '0;
        end
        default: begin
          r_rc <= '0;
        end
      endcase
    end
  end

  always_comb begin
    Busy_o  = (r_fsm != c_ST_IDLE);
    Done_o  = r_done;
    Data_ob = r_state[63 -: BUS_W];
  end

endmodule
`default_nettype wire

// File: doc/fosfor_present_core.md
FOSFOR_PRESENT_CORE -- requirements
Module: fosfor_present_core

Interface
REQ-001 Parameter KEY_W, default 80, key length; legal values 80 (PRESENT-80) and 128 (PRESENT-128) only.
REQ-002 Parameter BUS_W, default 8, data bus width; legal values 4, 8, 16 only.
REQ-003 Clk_k  input  1  clock; all state changes on the rising edge.
REQ-004 Reset_rn  input  1  asynchronous active-low reset.
REQ-005 Data_ib  input  BUS_W  write data for key and block loads.
REQ-006 KeyWr_i  input  1  shifts Data_ib into the key register.
REQ-007 DataWr_i  input  1  shifts Data_ib into the 64-bit state register.
REQ-008 DataRd_i  input  1  shifts the state register out by BUS_W bits.
REQ-009 Start_i  input  1  starts encryption of the loaded block.
REQ-010 Data_ob  output  BUS_W  always equal to state[63:64-BUS_W].
REQ-011 Busy_o  output  1  high while encrypting.
REQ-012 Done_o  output  1  one-cycle pulse when the ciphertext is valid in the state register.

Function
REQ-013 FSM states: IDLE, RUN, FINAL; 5-bit round counter rc.
REQ-014 In IDLE, KeyWr_i: key <= {key[KEY_W-BUS_W-1:0], Data_ib}, MSB word first; KEY_W/BUS_W writes load a full key.
REQ-015 In IDLE, DataWr_i: state <= {state[63-BUS_W:0], Data_ib}; DataRd_i alone: state <= {state[63-BUS_W:0], 0}.
REQ-016 DataWr_i and DataRd_i together in IDLE: single shift with Data_ib entering at the bottom (streaming read-out plus load).
REQ-017 Start_i in IDLE: go to RUN, rc <= 1, Busy_o high from the next cycle; Start_i has priority, so writes/reads in the same cycle are dropped.
REQ-018 RUN, each cycle: state <= pLayer(sBox(state ^ key[KEY_W-1:KEY_W-64])); key updated per the PRESENT schedule for KEY_W with rc; rc++.
REQ-019 Key schedule 80: rotate left 61, S-box on bits 79:76, XOR rc into bits 19:15; 128: rotate left 61, S-box on 127:124 and 123:120, XOR rc into bits 66:62.
REQ-020 After the round with rc = 31, go to FINAL; FINAL: state <= state ^ key[KEY_W-1:KEY_W-64], go to IDLE, Done_o = 1 for that one cycle, Busy_o low.
REQ-021 Latency: Start_i sampled at edge E0 gives the ciphertext and Done_o after edge E32; Busy_o high from after E0 until E32; Done_o low after E33.
REQ-022 Start_i, KeyWr_i, DataWr_i, DataRd_i are ignored while Busy_o is high.
REQ-023 Start_i asserted in the Done_o cycle is accepted; back-to-back runs need no idle gap.

Reset
REQ-024 Reset_rn low asynchronously forces IDLE, rc = 0, state = 0, key = 0 (and shadow key), Busy_o = 0, Done_o = 0, Data_ob = 0.
REQ-025 Reset mid-run aborts the operation; no Done_o is produced; the first edge after release behaves as IDLE.

Configuration
REQ-026 Macro FOSFOR_PRESENT_KEY_RETAIN_EN defined: KeyWr_i writes a KEY_W shadow register, and the working key is copied from the shadow on Start_i acceptance; the key persists across blocks.
REQ-027 Macro undefined: no shadow register; KeyWr_i writes the working key directly, which holds round key 32 after a run, so the key must be reloaded before every block.

Verification
REQ-028 KEY_W=80, BUS_W=8, key 0, block 0, Start -> Done_o after E32, read-out 5579C1387B228445.
REQ-029 KEY_W=80, key FFFFFFFFFFFFFFFFFFFF, block 0 -> E72C46C0F5945049; block FFFFFFFFFFFFFFFF, key 0 -> A112FFC72F68417B.
REQ-030 KEY_W=128, key 0, block 0 -> 96DB702A2E6900AF; repeat with BUS_W=4 and BUS_W=16 for identical results.
REQ-031 Writes, reads and Start pulsed at rc = 10 -> no effect on the result or latency; Start in the Done_o cycle -> second Done_o exactly 33 cycles after the first.
REQ-032 Reset_rn low at rc = 15 -> all outputs 0 immediately, no Done_o; a fresh run then gives the correct vector.
REQ-033 With the macro: one key load, two blocks (0 then FF..FF) -> both REQ-028/029 vectors; without the macro: a second block without key reload gives a mismatch.
